demod_rx_ctrl: RTL and testbench
================================

Name: demod_rx_ctrl

Overview:
- Receive-side sequencer for the QPSK demodulator chain.
- Holds the Gardner sync, IQ combiner and frame-check stages in reset while the mixer/low-pass pipeline fills.
- Hunts for a frame header, times the frame and forwards validated 40-bit payloads.
- Forces a re-synchronisation of the chain after header timeouts or repeated bad frames; reports lock and frame statistics.
- Runs in the 500 kHz sample-clock domain, between the frame-check stage and the payload consumer.

Parameters:
- WARMUP_CYC, 200: clk cycles chain_rst_n is held low after reset/enable, covering FIR and DDS pipeline fill.
- FRAME_SYNCS, 28: sync_flag pulses allowed after a header before the frame is declared bad (56-bit frame, 2 bits/symbol).
- HUNT_TIMEOUT, 64: sync_flag pulses without header_flag before a resync is forced.
- MAX_ERR, 3: consecutive bad frames that force a resync.
- RST_HOLD, 4: clk cycles chain_rst_n is held low in RESYNC.

Ports:
- clk  in  1  500 kHz sample clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  receiver enable
- sync_flag  in  1  symbol decision strobe, one cycle
- header_flag  in  1  header detected, one cycle
- valid_flag  in  1  header and checksum correct, one cycle; para_in valid in the same cycle
- para_in  in  40  payload from the frame-check stage
- chain_rst_n  out  1  synchronous active-low reset to the sync, combine and check stages
- frame_data  out  40  last accepted payload
- frame_vld  out  1  one-cycle pulse when frame_data updates
- lock  out  1  at least one good frame since the last resync
- state  out  2  0=WARMUP, 1=HUNT, 2=RECV, 3=RESYNC
- good_cnt  out  16  good frames
- err_cnt  out  16  bad frames

Behaviour:
- Single clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state=WARMUP, chain_rst_n=0, frame_vld=0, frame_data=0, lock=0.
  - good_cnt=0, err_cnt=0.
  - Internal counters (cycle, sync, consecutive-error) = 0.
- enable=0 (any state, rst_n high): next state WARMUP, cycle counter cleared, chain_rst_n=0, lock=0. Statistics and frame_data are held.
- WARMUP:
  - chain_rst_n=0; cycle counter increments each clk.
  - When the counter reaches WARMUP_CYC-1 (and enable=1): go to HUNT, chain_rst_n=1 from the next cycle.
- HUNT:
  - Sync counter increments on each sync_flag.
  - header_flag=1: go to RECV and clear the sync counter. header_flag wins over a timeout in the same cycle.
  - Counter reaches HUNT_TIMEOUT: go to RESYNC.
- RECV:
  - Sync counter increments on each sync_flag; header_flag is ignored.
  - valid_flag=1: register para_in into frame_data, pulse frame_vld for one cycle (latency one clk from the valid_flag edge), good_cnt+1, consecutive-error=0, lock=1, go to HUNT with the sync counter cleared.
  - Counter reaches FRAME_SYNCS without valid_flag: err_cnt+1, consecutive-error+1.
    - If the consecutive-error count now equals MAX_ERR: go to RESYNC.
    - Otherwise: go to HUNT.
  - valid_flag in the same cycle as the counter limit: treated as a good frame.
- RESYNC:
  - On entry, lock=0 and consecutive-error=0.
  - chain_rst_n=0 for exactly RST_HOLD cycles, then HUNT with chain_rst_n=1 and counters cleared.
  - WARMUP is not repeated; the FIR is not reset.
- valid_flag outside RECV is ignored (no frame_vld).
- frame_vld is never high for two consecutive cycles.
- good_cnt and err_cnt saturate at 16'hFFFF.
- Counter widths are sized by $clog2 of their parameter.

Optional Feature:
- Macro: DEMOD_CTRL_STATS_EN.
- Defined: good_cnt and err_cnt behave as specified above.
- Undefined: both counters are removed and their outputs are tied to 16'd0. All other behaviour is unchanged.

Test Plan:
- Reset, enable=1, no stimulus -> chain_rst_n=0 for 200 cycles, state goes to 1 at cycle 200, chain_rst_n=1.
- HUNT, header_flag, valid_flag 20 syncs later with para_in=40'h12_3456_789A -> frame_vld one-cycle pulse one clk later, frame_data=40'h12_3456_789A, good_cnt=1, lock=1, state=1.
- Three headers each followed by 28 syncs with no valid_flag -> err_cnt=3, state=3 with chain_rst_n=0 for 4 cycles, then state=1, lock=0.
- HUNT with 64 syncs and no header -> state=3; header_flag coincident with the 64th sync -> state=2 instead.
- enable dropped mid-RECV -> next cycle state=0, chain_rst_n=0, counts held. rst_n low mid-RECV -> all outputs at reset values on the next edge.
- Build without DEMOD_CTRL_STATS_EN, repeat the good-frame test -> good_cnt=err_cnt=0, frame_vld and frame_data unchanged.

Source files
------------

// File: rtl/demod_rx_ctrl.sv
// demod_rx_ctrl: receive-side sequencer for the QPSK demodulator chain.
// Holds the sync/combine/check stages in reset while the mixer/FIR pipeline
// fills, hunts for frame headers, times each frame in symbol strobes and
// forwards validated payloads. Forces a chain resync after a header timeout
// or after MAX_ERR consecutive bad frames.
//
// Build option: define DEMOD_CTRL_STATS_EN to keep the good/bad frame
// counters; without it good_cnt and err_cnt are tied to zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WARMUP(0) | chain held in reset while the FIR/DDS pipeline fills
// HUNT(1)   | chain running, waiting for header_flag, timing out on syncs
// RECV(2)   | header seen, waiting for valid_flag within FRAME_SYNCS syncs
// RESYNC(3) | chain held in reset for RST_HOLD cycles, then back to HUNT
module demod_rx_ctrl #(
  parameter int WARMUP_CYC   = 200,
  parameter int FRAME_SYNCS  = 28,
  parameter int HUNT_TIMEOUT = 64,
  parameter int MAX_ERR      = 3,
  parameter int RST_HOLD     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sync_flag,
  input  logic        header_flag,
  input  logic        valid_flag,
  input  logic [39:0] para_in,
  output logic        chain_rst_n,
  output logic [39:0] frame_data,
  output logic        frame_vld,
  output logic        lock,
  output logic [1:0]  state,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt
);

  // One cycle counter serves both the warm-up and the resync hold.
  localparam int CYC_MAX  = (WARMUP_CYC > RST_HOLD) ? WARMUP_CYC : RST_HOLD;
  localparam int CYC_W    = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  // The sync counter must be able to hold the limit value itself.
  localparam int SYNC_MAX = (FRAME_SYNCS > HUNT_TIMEOUT) ? FRAME_SYNCS : HUNT_TIMEOUT;
  localparam int SYNC_W   = $clog2(SYNC_MAX + 1);
  localparam int ERR_W    = $clog2(MAX_ERR + 1);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_HUNT   = 2'd1,
    ST_RECV   = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

  state_t            r_state;
  logic [CYC_W-1:0]  r_cyc;
  logic [SYNC_W-1:0] r_sync;
  logic [ERR_W-1:0]  r_cerr;
  logic              r_chain_rst_n;
  logic              r_lock;
  logic              r_frame_vld;
  logic [39:0]       r_frame_data;

  state_t            w_state_nxt;
  logic [CYC_W-1:0]  w_cyc_nxt;
  logic [SYNC_W-1:0] w_sync_nxt;
  logic              w_good;
  logic              w_bad;
  logic              w_enter_resync;

  // Next-state, counter updates and frame verdicts.
  always_comb begin
    w_state_nxt    = r_state;
    w_cyc_nxt      = r_cyc + CYC_W'(1);
    w_sync_nxt     = r_sync + SYNC_W'(sync_flag);
    w_good         = 1'b0;
    w_bad          = 1'b0;
    w_enter_resync = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_WARMUP;
      w_cyc_nxt   = '0;
      w_sync_nxt  = '0;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          w_sync_nxt = '0;
          if (r_cyc == CYC_W'(WARMUP_CYC - 1)) begin
            w_state_nxt = ST_HUNT;
            w_cyc_nxt   = '0;
          end
        end
        ST_HUNT: begin
          w_cyc_nxt = '0;
          // A header beats a timeout landing in the same cycle.
          if (header_flag) begin
            w_state_nxt = ST_RECV;
            w_sync_nxt  = '0;
          end else if (sync_flag && (r_sync == SYNC_W'(HUNT_TIMEOUT - 1))) begin
            w_state_nxt    = ST_RESYNC;
            w_sync_nxt     = '0;
            w_enter_resync = 1'b1;
          end
        end
        ST_RECV: begin
          w_cyc_nxt = '0;
          // A valid frame on the last allowed sync still counts as good.
          if (valid_flag) begin
            w_good      = 1'b1;
            w_state_nxt = ST_HUNT;
            w_sync_nxt  = '0;
          end else if (sync_flag && (r_sync == SYNC_W'(FRAME_SYNCS - 1))) begin
            w_bad      = 1'b1;
            w_sync_nxt = '0;
            if (r_cerr == ERR_W'(MAX_ERR - 1)) begin
              w_state_nxt    = ST_RESYNC;
              w_enter_resync = 1'b1;
            end else begin
              w_state_nxt = ST_HUNT;
            end
          end
        end
        ST_RESYNC: begin
          w_sync_nxt = '0;
          if (r_cyc == CYC_W'(RST_HOLD - 1)) begin
            w_state_nxt = ST_HUNT;
            w_cyc_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_WARMUP;
          w_cyc_nxt   = '0;
          w_sync_nxt  = '0;
        end
      endcase
    end
  end

  // State register, counters and a glitch-free registered chain reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_WARMUP;
      r_cyc         <= '0;
      r_sync        <= '0;
      r_chain_rst_n <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cyc         <= w_cyc_nxt;
      r_sync        <= w_sync_nxt;
      r_chain_rst_n <= (w_state_nxt == ST_HUNT) || (w_state_nxt == ST_RECV);
    end
  end

  // Consecutive-error count and lock indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cerr <= '0;
      r_lock <= 1'b0;
    end else if (!enable) begin
      r_cerr <= '0;
      r_lock <= 1'b0;
    end else if (w_good) begin
      r_cerr <= '0;
      r_lock <= 1'b1;
    end else if (w_enter_resync) begin
      r_cerr <= '0;
      r_lock <= 1'b0;
    end else if (w_bad) begin
      r_cerr <= r_cerr + ERR_W'(1);
    end
  end

  // Payload capture with a one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_vld  <= 1'b0;
      r_frame_data <= '0;
    end else begin
      r_frame_vld <= w_good;
      if (w_good) begin
        r_frame_data <= para_in;
      end
    end
  end

`ifdef DEMOD_CTRL_STATS_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_err_cnt;

  // Saturating good/bad frame statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_good_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_good && (r_good_cnt != 16'hFFFF)) begin
        r_good_cnt <= r_good_cnt + 16'd1;
      end
      if (w_bad && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign good_cnt = r_good_cnt;
  assign err_cnt  = r_err_cnt;
`else
  assign good_cnt = 16'd0;
  assign err_cnt  = 16'd0;
`endif

  assign chain_rst_n = r_chain_rst_n;
  assign frame_data  = r_frame_data;
  assign frame_vld   = r_frame_vld;
  assign lock        = r_lock;
  assign state       = r_state;

endmodule

// File: tb/tb_demod_rx_ctrl.sv
// Directed bench for demod_rx_ctrl: warm-up, good frame, bad frames into
// resync, hunt timeout, header/timeout race, enable drop and reset.
module tb_demod_rx_ctrl;

`ifdef DEMOD_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        sync_flag;
  logic        header_flag;
  logic        valid_flag;
  logic [39:0] para_in;
  logic        chain_rst_n;
  logic [39:0] frame_data;
  logic        frame_vld;
  logic        lock;
  logic [1:0]  state;
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  demod_rx_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sync_flag   (sync_flag),
    .header_flag (header_flag),
    .valid_flag  (valid_flag),
    .para_in     (para_in),
    .chain_rst_n (chain_rst_n),
    .frame_data  (frame_data),
    .frame_vld   (frame_vld),
    .lock        (lock),
    .state       (state),
    .good_cnt    (good_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n sync strobes, each followed by an idle cycle.
  task automatic syncs(input int n);
    for (int i = 0; i < n; i++) begin
      sync_flag = 1'b1;
      tick();
      sync_flag = 1'b0;
      tick();
    end
  endtask

  function automatic logic [15:0] st(input int v);
    return STATS ? 16'(v) : 16'd0;
  endfunction

  initial begin
    #100us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; sync_flag = 1'b0;
    header_flag = 1'b0; valid_flag = 1'b0; para_in = '0;
    tick(); tick();
    chk("rst_state", state, 2'd0);
    chk("rst_chain", chain_rst_n, 1'b0);
    chk("rst_vld", frame_vld, 1'b0);
    chk("rst_data", frame_data, 40'd0);
    chk("rst_lock", lock, 1'b0);
    chk("rst_good", good_cnt, 16'd0);
    chk("rst_err", err_cnt, 16'd0);

    // Warm-up: 200 cycles in WARMUP, HUNT on the 200th edge.
    rst_n = 1'b1; enable = 1'b1;
    for (int i = 0; i < 199; i++) tick();
    chk("warm_state_199", state, 2'd0);
    chk("warm_chain_199", chain_rst_n, 1'b0);
    tick();
    chk("warm_state_200", state, 2'd1);
    chk("warm_chain_200", chain_rst_n, 1'b1);

    // valid_flag in HUNT is ignored.
    valid_flag = 1'b1; para_in = 40'hAA_BBCC_DDEE;
    tick();
    valid_flag = 1'b0;
    chk("hunt_valid_vld", frame_vld, 1'b0);
    chk("hunt_valid_data", frame_data, 40'd0);

    // Good frame: header, valid on the 20th sync.
    header_flag = 1'b1; tick(); header_flag = 1'b0;
    chk("hdr_state", state, 2'd2);
    syncs(19);
    chk("recv_state", state, 2'd2);
    sync_flag = 1'b1; valid_flag = 1'b1; para_in = 40'h12_3456_789A;
    tick();
    sync_flag = 1'b0; valid_flag = 1'b0; para_in = '0;
    chk("good_vld", frame_vld, 1'b1);
    chk("good_data", frame_data, 40'h12_3456_789A);
    chk("good_cnt1", good_cnt, st(1));
    chk("good_lock", lock, 1'b1);
    chk("good_state", state, 2'd1);
    tick();
    chk("good_vld_off", frame_vld, 1'b0);

    // Three bad frames: 28 syncs each without valid.
    for (int f = 0; f < 3; f++) begin
      header_flag = 1'b1; tick(); header_flag = 1'b0;
      syncs(27);
      chk("bad_recv_27", state, 2'd2);
      sync_flag = 1'b1; tick(); sync_flag = 1'b0;
      chk("bad_err", err_cnt, st(f + 1));
      chk("bad_state", state, (f == 2) ? 2'd3 : 2'd1);
    end
    chk("rsy_chain0", chain_rst_n, 1'b0);
    chk("rsy_lock", lock, 1'b0);
    chk("rsy_good", good_cnt, st(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rsy_hold_state", state, 2'd3);
      chk("rsy_hold_chain", chain_rst_n, 1'b0);
    end
    tick();
    chk("rsy_exit_state", state, 2'd1);
    chk("rsy_exit_chain", chain_rst_n, 1'b1);
    chk("rsy_exit_lock", lock, 1'b0);

    // Hunt timeout after 64 syncs.
    syncs(63);
    chk("to_63_state", state, 2'd1);
    sync_flag = 1'b1; tick(); sync_flag = 1'b0;
    chk("to_64_state", state, 2'd3);
    for (int i = 0; i < 4; i++) tick();
    chk("to_back_hunt", state, 2'd1);
    chk("to_err_held", err_cnt, st(3));

    // Header coincident with the 64th sync wins.
    syncs(63);
    sync_flag = 1'b1; header_flag = 1'b1; tick();
    sync_flag = 1'b0; header_flag = 1'b0;
    chk("race_state", state, 2'd2);

    // Second good frame, then enable dropped mid-RECV.
    syncs(3);
    valid_flag = 1'b1; para_in = 40'hFE_DCBA_9876; tick();
    valid_flag = 1'b0; para_in = '0;
    chk("good2_data", frame_data, 40'hFE_DCBA_9876);
    chk("good2_cnt", good_cnt, st(2));
    chk("good2_lock", lock, 1'b1);
    header_flag = 1'b1; tick(); header_flag = 1'b0;
    syncs(5);
    enable = 1'b0; tick();
    chk("en_state", state, 2'd0);
    chk("en_chain", chain_rst_n, 1'b0);
    chk("en_lock", lock, 1'b0);
    chk("en_good", good_cnt, st(2));
    chk("en_err", err_cnt, st(3));
    chk("en_data", frame_data, 40'hFE_DCBA_9876);

    // Warm-up repeats after re-enable.
    enable = 1'b1;
    for (int i = 0; i < 199; i++) tick();
    chk("rewarm_199", state, 2'd0);
    tick();
    chk("rewarm_200", state, 2'd1);

    // Synchronous reset mid-RECV.
    header_flag = 1'b1; tick(); header_flag = 1'b0;
    syncs(2);
    chk("pre_rst_state", state, 2'd2);
    rst_n = 1'b0; tick();
    chk("rst2_state", state, 2'd0);
    chk("rst2_chain", chain_rst_n, 1'b0);
    chk("rst2_vld", frame_vld, 1'b0);
    chk("rst2_data", frame_data, 40'd0);
    chk("rst2_lock", lock, 1'b0);
    chk("rst2_good", good_cnt, 16'd0);
    chk("rst2_err", err_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
